// File: rtl/bounce_gen_amisha_pkg.sv
// Shared definitions for the bounce emitter: state encodings, LFSR taps and
// fallback seed, plus the LFSR step function.
package bounce_gen_amisha_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BOUNCE = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  // Taps 16,14,13,11 expressed as a bit mask over lfsr[15:0].
  localparam logic [15:0] LFSR_TAPS          = 16'hB400;
  localparam logic [15:0] LFSR_FALLBACK_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bounce_gen_amisha_lfsr16.sv
// 16-bit Fibonacci LFSR that steps only when advance is high.
// A zero SEED would lock up, so it is replaced by the fallback seed.
module lfsr16_amisha
  import bounce_gen_amisha_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  output logic [15:0] lfsr
);

  localparam logic [15:0] INIT = (SEED == 16'h0000) ? LFSR_FALLBACK_SEED : SEED;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= INIT;
    end else if (advance) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

endmodule

// File: rtl/bounce_gen_amisha.sv
// Contact-bounce emitter: drives btn_out through a pseudo-random glitch burst
// before settling at the commanded level. BOUNCE_GEN_ABORT_EN adds abort_amisha.
module bounce_gen_amisha
  import bounce_gen_amisha_pkg::*;
#(
  parameter int          N_BOUNCE     = 3,
  parameter int          MIN_GAP      = 4,
  parameter int          GAP_BITS     = 4,
  parameter int          STABLE_TICKS = 32,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic clk_amisha,
  input  logic reset_amisha,
  input  logic cmd_valid_amisha,
  input  logic cmd_level_amisha,
`ifdef BOUNCE_GEN_ABORT_EN
  input  logic abort_amisha,
`endif
  output logic cmd_ready_amisha,
  output logic btn_out_amisha,
  output logic busy_amisha,
  output logic done_tick_amisha
);

  localparam int          SW          = $clog2(STABLE_TICKS + 1);
  localparam logic [6:0]  TOGGLES     = 7'(2 * N_BOUNCE + 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(STABLE_TICKS);
  localparam logic [8:0]  MIN_GAP_M1  = 9'(MIN_GAP - 1);

  state_t          state_q, state_d;
  logic            btn_q, target_q;
  logic [6:0]      toggle_cnt_q;
  logic [8:0]      gap_cnt_q, gap_load;
  logic [SW-1:0]   settle_cnt_q;
  logic [15:0]     lfsr;
  logic            accept, toggle_now, last_toggle, settle_done, abort_hit;
  logic            unused_lfsr_bits;

  assign accept      = cmd_valid_amisha && (state_q == ST_IDLE);
  assign toggle_now  = (state_q == ST_BOUNCE) && (gap_cnt_q == 9'd0);
  assign last_toggle = toggle_now && (toggle_cnt_q == 7'd1);
  assign settle_done = (state_q == ST_SETTLE) && (settle_cnt_q == '0);
  assign gap_load    = MIN_GAP_M1 + {{(9-GAP_BITS){1'b0}}, lfsr[GAP_BITS-1:0]};
  assign unused_lfsr_bits = ^lfsr;

`ifdef BOUNCE_GEN_ABORT_EN
  // A final settle count wins over abort so only one done_tick is produced.
  assign abort_hit = abort_amisha && (state_q != ST_IDLE) && !settle_done;
`else
  assign abort_hit = 1'b0;
`endif

  lfsr16_amisha #(.SEED(SEED)) u_lfsr (
    .clk     (clk_amisha),
    .reset   (reset_amisha),
    .advance (toggle_now && !abort_hit),
    .lfsr    (lfsr)
  );

  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = (cmd_level_amisha != btn_q) ? ST_BOUNCE : ST_SETTLE;
      end
      ST_BOUNCE: begin
        if (abort_hit || last_toggle) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Abort is folded into SETTLE with a zero count so done_tick has one source.
  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      btn_q        <= 1'b0;
      target_q     <= 1'b0;
      toggle_cnt_q <= 7'd0;
      gap_cnt_q    <= 9'd0;
      settle_cnt_q <= '0;
    end else if (accept) begin
      target_q     <= cmd_level_amisha;
      toggle_cnt_q <= TOGGLES;
      gap_cnt_q    <= 9'd0;
      settle_cnt_q <= SETTLE_LOAD;
    end else if (abort_hit) begin
      btn_q        <= target_q;
      settle_cnt_q <= '0;
    end else if (toggle_now) begin
      btn_q        <= ~btn_q;
      toggle_cnt_q <= toggle_cnt_q - 7'd1;
      gap_cnt_q    <= gap_load;
      if (last_toggle) settle_cnt_q <= SETTLE_LOAD;
    end else if (state_q == ST_BOUNCE) begin
      gap_cnt_q    <= gap_cnt_q - 9'd1;
    end else if ((state_q == ST_SETTLE) && (settle_cnt_q != '0)) begin
      settle_cnt_q <= settle_cnt_q - SW'(1);
    end
  end

  always_comb begin
    cmd_ready_amisha = 1'b0;
    busy_amisha      = 1'b0;
    done_tick_amisha = 1'b0;
    case (state_q)
      ST_IDLE:   cmd_ready_amisha = 1'b1;
      ST_BOUNCE: busy_amisha      = 1'b1;
      ST_SETTLE: begin
        busy_amisha      = 1'b1;
        done_tick_amisha = settle_done;
      end
      default:   cmd_ready_amisha = 1'b0;
    endcase
  end

  assign btn_out_amisha = btn_q;

endmodule

// File: tb/tb_bounce_gen_amisha.sv
// Directed bench for bounce_gen_amisha with N_BOUNCE=2, MIN_GAP=3, GAP_BITS=2,
// STABLE_TICKS=8; gap sequences are hand-computed from the ACE1 LFSR.
module tb_bounce_gen_amisha;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_level = 1'b0;
`ifdef BOUNCE_GEN_ABORT_EN
  logic abort = 1'b0;
`endif
  logic cmd_ready, btn_out, busy, done_tick;

  int n_checks = 0;
  int n_errors = 0;
  logic [8:0] exp_q[$];

  bounce_gen_amisha #(
    .N_BOUNCE(2), .MIN_GAP(3), .GAP_BITS(2), .STABLE_TICKS(8), .SEED(16'hACE1)
  ) dut (
    .clk_amisha       (clk),
    .reset_amisha     (rst),
    .cmd_valid_amisha (cmd_valid),
    .cmd_level_amisha (cmd_level),
`ifdef BOUNCE_GEN_ABORT_EN
    .abort_amisha     (abort),
`endif
    .cmd_ready_amisha (cmd_ready),
    .btn_out_amisha   (btn_out),
    .busy_amisha      (busy),
    .done_tick_amisha (done_tick)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: hold valid until ready, return just after the accept edge
  task automatic send_cmd(input logic level);
    int waited = 0;
    cmd_valid = 1'b1;
    cmd_level = level;
    while (!cmd_ready && waited < 50) begin
      tick();
      waited++;
    end
    check("ready_wait", waited < 50, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // scoreboard: edge timing against exp_q, then settle and done timing
  task automatic measure_run(input int exp_edges, input logic exp_final);
    int cyc = 0;
    int edges = 0;
    int last_edge = 0;
    int done_cyc = -1;
    logic prev;
    prev = btn_out;
    check("busy_after_accept", busy, 1);
    while (cyc < 400 && done_cyc < 0) begin
      tick();
      cyc++;
      if (btn_out !== prev) begin
        edges++;
        if (edges == 1) check("first_edge_latency", cyc, 1);
        else if (exp_q.size() > 0) check("gap", cyc - last_edge, exp_q.pop_front());
        else check("extra_edge", edges, exp_edges);
        last_edge = cyc;
        prev = btn_out;
      end
      if (done_tick) done_cyc = cyc;
    end
    check("run_timeout", done_cyc >= 0, 1);
    check("edge_count", edges, exp_edges);
    check("gaps_left", exp_q.size(), 0);
    check("final_level", btn_out, exp_final);
    check("done_delay", done_cyc - last_edge, 8);
    tick();
    check("done_single", done_tick, 0);
    check("ready_after_done", cmd_ready, 1);
    check("idle_not_busy", busy, 0);
  endtask

  task automatic wait_edges(input int n);
    int seen = 0;
    int cyc = 0;
    logic prev;
    prev = btn_out;
    while (seen < n && cyc < 100) begin
      tick();
      cyc++;
      if (btn_out !== prev) begin
        seen++;
        prev = btn_out;
      end
    end
    check("edge_wait", seen, n);
  endtask

  initial begin
    int cyc;
    int early_ready;
    logic done_seen;

    // 1: reset held 200 ns
    #150;
    check("rst_btn", btn_out, 0);
    check("rst_ready", cmd_ready, 1);
    #50 rst = 1'b0;
    tick();
    check("post_rst_btn", btn_out, 0);
    check("post_rst_ready", cmd_ready, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done_tick, 0);

    // 2: 0 -> 1, gaps from lfsr ACE1,59C3,B387,670F
    exp_q = '{9'd4, 9'd6, 9'd6, 9'd6};
    send_cmd(1'b1);
    measure_run(5, 1'b1);

    // 3: same level, settle only
    exp_q.delete();
    send_cmd(1'b1);
    measure_run(0, 1'b1);

    // 4: valid held through a run; re-request for 0 after done_tick
    cmd_valid = 1'b1;
    cmd_level = 1'b1;
    tick();
    check("hold_busy", busy, 1);
    cyc = 0;
    early_ready = 0;
    done_seen = 1'b0;
    while (cyc < 50 && !done_seen) begin
      tick();
      cyc++;
      if (cmd_ready) early_ready++;
      if (done_tick) begin
        done_seen = 1'b1;
        cmd_level = 1'b0;
      end
    end
    check("hold_done_seen", done_seen, 1);
    check("hold_done_cyc", cyc, 8);
    check("hold_no_early_ready", early_ready, 0);
    tick();
    check("hold_ready_after_done", cmd_ready, 1);
    tick();
    check("hold_reaccept_busy", busy, 1);
    check("hold_reaccept_ready", cmd_ready, 0);
    cmd_valid = 1'b0;
    // lfsr continues from 9C3C,3879,70F2,E1E4
    exp_q = '{9'd3, 9'd4, 9'd5, 9'd3};
    measure_run(5, 1'b0);

    // 5: async reset inside the third gap, then replay of scenario 2
    send_cmd(1'b1);
    wait_edges(3);
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("async_rst_btn", btn_out, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_ready", cmd_ready, 1);
    check("async_rst_done", done_tick, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    exp_q = '{9'd4, 9'd6, 9'd6, 9'd6};
    send_cmd(1'b1);
    measure_run(5, 1'b1);

`ifdef BOUNCE_GEN_ABORT_EN
    // 6: abort after the second toggle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    send_cmd(1'b1);
    wait_edges(2);
    check("abort_pre_btn", btn_out, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_btn", btn_out, 1);
    check("abort_done", done_tick, 1);
    check("abort_not_ready", cmd_ready, 0);
    tick();
    check("abort_ready", cmd_ready, 1);
    check("abort_done_once", done_tick, 0);
    check("abort_btn_hold", btn_out, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
